// File: rtl/memory_arbiter_if.sv
// Cache-side request/response and RAM command bus shared by the arbiter and its clients.
// The slave modport is the arbiter; the master modport is the caches plus the RAM model.
interface memory_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        iwait;
   logic        dwait;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter onto a single RAM, with alternating tie-break,
// ERROR/timeout abort returning ERRWORD, and a sticky err flag.
module memory_arbiter #(
   parameter int          TIMEOUT = 64,
   parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
   input logic              CLK,
   input logic              nRST,
   memory_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

   localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0]     RS_ACCESS = 2'd2;
   localparam logic [1:0]     RS_ERROR  = 2'd3;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_i;
   logic          ren_q, wen_q, err_q;
   logic [31:0]   addr_q, store_q;

   logic        acc, hit, abort, done, dreq, ireq, grant_d;
   logic [31:0] resp;

   assign acc     = (state == DACC) || (state == IACC);
   assign hit     = acc && (bus.ramstate == RS_ACCESS);
   assign abort   = acc && !hit && ((bus.ramstate == RS_ERROR) || (cnt == CNT_LAST));
   assign done    = hit || abort;
   assign resp    = abort ? ERRWORD : bus.ramload;
   assign dreq    = bus.dREN || bus.dWEN;
   assign ireq    = bus.iREN;
   // On a tie the side that did not win last time gets the RAM.
   assign grant_d = dreq && (!ireq || last_i);

   assign bus.iwait    = !((state == IACC) && done);
   assign bus.dwait    = !((state == DACC) && done);
   assign bus.iload    = ((state == IACC) && done) ? resp : '0;
   assign bus.dload    = ((state == DACC) && done) ? resp : '0;
   assign bus.ramREN   = ren_q;
   assign bus.ramWEN   = wen_q;
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;
   assign bus.err      = err_q;

   // The RAM command registers double as the request latches, so a granted
   // access is immune to requests changing or dropping underneath it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         cnt     <= '0;
         last_i  <= 1'b1;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_d) begin
                  state   <= DACC;
                  last_i  <= 1'b0;
                  wen_q   <= bus.dWEN;
                  ren_q   <= !bus.dWEN;
                  addr_q  <= bus.daddr;
                  store_q <= bus.dWEN ? bus.dstore : '0;
               end else if (ireq) begin
                  state   <= IACC;
                  last_i  <= 1'b1;
                  wen_q   <= 1'b0;
                  ren_q   <= 1'b1;
                  addr_q  <= bus.iaddr;
                  store_q <= '0;
               end
            end
            DACC, IACC: begin
               if (done) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  addr_q  <= '0;
                  store_q <= '0;
                  if (abort) err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares whenever iwait or dwait drops.
module tb_memory_arbiter;
   localparam logic [31:0] ERRW = 32'hBAD1BAD1;
   localparam int M_OK = 0, M_ERR = 1, M_HANG = 2;

   typedef struct {
      bit          side;   // 1 = data, 0 = instruction
      logic [31:0] data;
   } exp_t;

   logic CLK = 1'b0;
   logic nRST;
   memory_arbiter_if bus();

   memory_arbiter #(.TIMEOUT(4), .ERRWORD(ERRW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   int          mode = M_OK;
   int          lat = 0;
   int          wcnt = 0;
   logic [31:0] load_val = '0;

   // RAM model: BUSY for lat cycles of a command, then the configured response.
   always_ff @(posedge CLK) wcnt <= (bus.ramREN || bus.ramWEN) ? wcnt + 1 : 0;

   always_comb begin
      bus.ramstate = 2'd0;
      if (bus.ramREN || bus.ramWEN) begin
         if (mode == M_HANG || wcnt < lat) bus.ramstate = 2'd1;
         else if (mode == M_ERR)          bus.ramstate = 2'd3;
         else                             bus.ramstate = 2'd2;
      end
      bus.ramload = load_val;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         if (!bus.iwait && !bus.dwait) begin
            total++; bad++;
            $display("FAIL both_waits_low: iwait=%0b dwait=%0b expected one high", bus.iwait, bus.dwait);
         end else if (!bus.iwait || !bus.dwait) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_completion: iwait=%0b dwait=%0b expected none", bus.iwait, bus.dwait);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("resp_side", {63'd0, !bus.dwait}, {63'd0, e.side});
               check("resp_data", {32'd0, (!bus.dwait ? bus.dload : bus.iload)}, {32'd0, e.data});
            end
         end
         if ((bus.iwait && bus.iload != 0) || (bus.dwait && bus.dload != 0)) begin
            total++; bad++;
            $display("FAIL load_while_wait: iload=%0h dload=%0h expected 0", bus.iload, bus.dload);
         end
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge CLK);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic push(input bit side, input logic [31:0] d);
      exp_t e;
      e.side = side;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
      repeat (2) tick();
      nRST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0;
      bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;
      #3;
      check("rst_iwait",   {63'd0, bus.iwait}, 64'd1);
      check("rst_dwait",   {63'd0, bus.dwait}, 64'd1);
      check("rst_loads",   {bus.iload, bus.dload}, 64'd0);
      check("rst_cmd",     {62'd0, bus.ramREN, bus.ramWEN}, 64'd0);
      check("rst_addrst",  {bus.ramaddr, bus.ramstore}, 64'd0);
      check("rst_err",     {63'd0, bus.err}, 64'd0);
      do_reset();

      // Instruction read, 2 BUSY cycles then ACCESS.
      mode = M_OK; lat = 2; load_val = 32'h1234;
      bus.iREN = 1; bus.iaddr = 32'h40;
      push(0, 32'h1234);
      tick();
      bus.iREN = 0;
      check("iacc_cmd",  {62'd0, bus.ramREN, bus.ramWEN}, 64'd2);
      check("iacc_addr", {bus.ramaddr, bus.ramstore}, {32'h40, 32'h0});
      drain(20);

      // Contention from reset: data first, then strict alternation.
      do_reset();
      mode = M_OK; lat = 0; load_val = 32'h5555;
      bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hAA;
      push(1, 32'h5555); push(0, 32'h5555); push(1, 32'h5555); push(0, 32'h5555);
      tick();
      check("tie_dwrite", {62'd0, bus.ramREN, bus.ramWEN}, 64'd1);
      check("tie_dstore", {bus.ramaddr, bus.ramstore}, {32'h80, 32'hAA});
      tick();
      check("tie_idle_gap", {62'd0, bus.ramREN, bus.ramWEN}, 64'd0);
      tick();
      check("tie_iread", {bus.ramaddr, bus.ramstore}, {32'h44, 32'h0});
      drain(40);
      bus.iREN = 0; bus.dWEN = 0;

      // RAM error on a data read; err stays set across a later good access.
      do_reset();
      check("err_cleared", {63'd0, bus.err}, 64'd0);
      mode = M_ERR; lat = 0;
      bus.dREN = 1; bus.daddr = 32'h100;
      push(1, ERRW);
      tick();
      bus.dREN = 0;
      drain(20);
      check("err_set", {63'd0, bus.err}, 64'd1);
      mode = M_OK; lat = 1; load_val = 32'h77;
      bus.iREN = 1; bus.iaddr = 32'h104;
      push(0, 32'h77);
      tick();
      bus.iREN = 0;
      drain(20);
      check("err_sticky", {63'd0, bus.err}, 64'd1);

      // Timeout with TIMEOUT=4: completes on the 4th IACC cycle.
      do_reset();
      mode = M_HANG;
      bus.iREN = 1; bus.iaddr = 32'h200;
      push(0, ERRW);
      tick();
      bus.iREN = 0;
      check("to_c1", {63'd0, bus.iwait}, 64'd1);
      tick();
      check("to_c2", {63'd0, bus.iwait}, 64'd1);
      tick();
      check("to_c3", {63'd0, bus.iwait}, 64'd1);
      tick();
      check("to_c4", {31'd0, bus.iwait, bus.iload}, {32'd0, ERRW});
      tick();
      check("to_err", {63'd0, bus.err}, 64'd1);
      drain(5);

      // Reset in the middle of a data access.
      do_reset();
      mode = M_HANG;
      bus.dREN = 1; bus.daddr = 32'h300;
      tick();
      bus.dREN = 0;
      check("mid_cmd_on", {62'd0, bus.ramREN, bus.ramWEN}, 64'd2);
      #2 nRST = 1'b0;
      #1;
      check("mid_rst_cmd", {62'd0, bus.ramREN, bus.ramWEN}, 64'd0);
      check("mid_rst_wait", {62'd0, bus.dwait, bus.err}, 64'd2);
      repeat (2) tick();
      nRST = 1'b1;
      mode = M_OK; lat = 0; load_val = 32'h600D;
      bus.iREN = 1; bus.iaddr = 32'h500; bus.dREN = 1; bus.daddr = 32'h400;
      push(1, 32'h600D);
      tick();
      check("post_rst_tie", {31'd0, bus.ramREN, bus.ramaddr}, {31'd0, 1'b1, 32'h400});
      drain(20);
      bus.iREN = 0; bus.dREN = 0;
      tick();

      // Request pulsed for one cycle still completes, then no further grant.
      mode = M_OK; lat = 3; load_val = 32'h99;
      bus.dREN = 1; bus.daddr = 32'h600;
      push(1, 32'h99);
      tick();
      bus.dREN = 0;
      drain(20);
      repeat (3) tick();
      check("drop_idle", {61'd0, bus.ramREN, bus.ramWEN, bus.dwait}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
